// File: rtl/d5m_pkg.sv
// Shared types and constants for the synthetic D5M sensor stream generator.
// Counter widths bound the legal frame geometry of the generator.
package d5m_pkg;

  localparam int unsigned X_W   = 12;
  localparam int unsigned Y_W   = 12;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PIX_W = 12;
  localparam int unsigned FC_W  = 32;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_ROM   = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FRONT  = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } state_e;

  // Bayer site index is {y[0], x[0]}
  localparam logic [1:0] SITE_G1 = 2'b00;
  localparam logic [1:0] SITE_R  = 2'b01;
  localparam logic [1:0] SITE_B  = 2'b10;
  localparam logic [1:0] SITE_G2 = 2'b11;

  function automatic logic [PIX_W-1:0] pix_level(input logic on);
    return on ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
  endfunction

endpackage

// File: rtl/d5m_pattern_lut.sv
// Combinational pixel generator: maps mode and pixel coordinates to a 12-bit Bayer sample.
// Carries no state; all timing is owned by the instantiating stream generator.
module d5m_pattern_lut
  import d5m_pkg::*;
#(
  parameter int unsigned BAR_SHIFT = 7
) (
  input  logic [1:0]       mode_i,
  input  logic [X_W-1:0]   x_i,
  input  logic [Y_W-1:0]   y_i,
  input  logic [PIX_W-1:0] frame_i,
  input  logic [PIX_W-1:0] rom_data_i,
  output logic [PIX_W-1:0] pixel_o
);

  logic [2:0]       bar_c;
  logic [PIX_W-1:0] bar_pix;

  always_comb begin
    bar_c   = 3'd7 - 3'(x_i >> BAR_SHIFT);
    bar_pix = pix_level(bar_c[1]);
    pixel_o = '0;

    // R and B sites take their own colour channel, both green sites share G
    case ({y_i[0], x_i[0]})
      SITE_R:  bar_pix = pix_level(bar_c[2]);
      SITE_B:  bar_pix = pix_level(bar_c[0]);
      SITE_G1,
      SITE_G2: bar_pix = pix_level(bar_c[1]);
      default: bar_pix = pix_level(bar_c[1]);
    endcase

    case (mode_e'(mode_i))
      MODE_BARS:  pixel_o = bar_pix;
      MODE_RAMP:  pixel_o = PIX_W'(x_i + y_i + frame_i);
      MODE_ROM:   pixel_o = rom_data_i;
      MODE_CHECK: pixel_o = pix_level(x_i[4] ^ y_i[4]);
      default:    pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/d5m_stream_gen.sv
// Synthetic D5M transmitter: FVAL/LVAL/12-bit Bayer stream with one registered output stage.
// Stands in for the camera so the capture/RAW2RGB/SDRAM/VGA chain can run standalone.
module d5m_stream_gen
  import d5m_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned V_ACTIVE  = 960,
  parameter int unsigned H_BLANK   = 160,
  parameter int unsigned FV2LV     = 32,
  parameter int unsigned V_BLANK   = 2000,
  parameter int unsigned BAR_SHIFT = 7,
  parameter int unsigned ROM_SHIFT = 3,
  parameter int unsigned ROM_W     = 160,
  parameter int unsigned ROM_AW    = 15
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iSTOP,
  input  logic [1:0]        iMODE,
  output logic [ROM_AW-1:0] oROM_ADDR,
  input  logic [11:0]       iROM_DATA,
  output logic [11:0]       oDATA,
  output logic              oFVAL,
  output logic              oLVAL,
  output logic [31:0]       oFrame_Cont,
  output logic              oBUSY
);

  localparam bit PARAMS_OK =
      (H_ACTIVE >= 1) && (H_ACTIVE <= (1 << X_W)) &&
      (V_ACTIVE >= 1) && (V_ACTIVE <= (1 << Y_W)) &&
      (H_BLANK  >= 1) && (H_BLANK  <= (1 << CNT_W)) &&
      (FV2LV    >= 1) && (FV2LV    <= (1 << CNT_W)) &&
      (V_BLANK  >= 1) && (V_BLANK  <= (1 << CNT_W)) &&
      (ROM_AW   >= 1) && (ROM_AW   <= 32);

  if (!PARAMS_OK) begin : g_bad_params
    $fatal(1, "d5m_stream_gen: frame geometry does not fit the counter widths");
  end

  state_e             state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stop_q, stop_d;
  mode_e              mode_q, mode_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic               busy_q;

  logic               fval_q;
  logic               lval_q;
  logic [X_W-1:0]     x1_q;
  logic [Y_W-1:0]     y1_q;
  logic [FC_W-1:0]    frame_q;
  logic [PIX_W-1:0]   pix_c;

  // Next-state logic for the frame timing FSM and its coordinate counters
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    stop_d     = stop_q;
    mode_d     = mode_q;
    rom_addr_d = '0;

    if (state_q != ST_IDLE && iSTOP) begin
      stop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (iSTART && !iSTOP) begin
          state_d = ST_FRONT;
          cnt_d   = '0;
          stop_d  = 1'b0;
          mode_d  = mode_e'(iMODE);
        end
      end
      ST_FRONT: begin
        if (cnt_q == CNT_W'(FV2LV - 1)) begin
          state_d = ST_LINE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LINE: begin
        if (x_q == X_W'(H_ACTIVE - 1)) begin
          state_d = ST_HBLANK;
          cnt_d   = '0;
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
      ST_HBLANK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          if (y_q == Y_W'(V_ACTIVE - 1)) begin
            state_d = ST_VBLANK;
            cnt_d   = '0;
          end else begin
            state_d = ST_LINE;
            x_d     = '0;
            y_d     = y_q + Y_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_VBLANK: begin
        if (cnt_q == CNT_W'(V_BLANK - 1)) begin
          if (stop_d) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = ST_FRONT;
            cnt_d   = '0;
            mode_d  = mode_e'(iMODE);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Address is registered from next-state coordinates so it lines up with stage 0
    if (state_d == ST_LINE) begin
      rom_addr_d = ROM_AW'(32'(y_d >> ROM_SHIFT) * 32'(ROM_W) + 32'(x_d >> ROM_SHIFT));
    end
  end

  // Stage 0: FSM state and coordinates
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      mode_q     <= MODE_BARS;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      stop_q     <= stop_d;
      mode_q     <= mode_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  // Stage 1: registered valids, delayed coordinates and the completed-frame count
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      frame_q <= '0;
    end else begin
      fval_q <= (state_q == ST_FRONT) || (state_q == ST_LINE) || (state_q == ST_HBLANK);
      lval_q <= (state_q == ST_LINE);
      x1_q   <= x_q;
      y1_q   <= y_q;
      if (state_q == ST_VBLANK && cnt_q == '0) begin
        frame_q <= frame_q + FC_W'(1);
      end
    end
  end

  // Pixel decode runs on stage-1 registers so ROM data returned for the stage-0 address lands on time
  d5m_pattern_lut #(
    .BAR_SHIFT (BAR_SHIFT)
  ) u_lut (
    .mode_i     (mode_q),
    .x_i        (x1_q),
    .y_i        (y1_q),
    .frame_i    (frame_q[PIX_W-1:0]),
    .rom_data_i (iROM_DATA),
    .pixel_o    (pix_c)
  );

  assign oDATA       = lval_q ? pix_c : '0;
  assign oFVAL       = fval_q;
  assign oLVAL       = lval_q;
  assign oFrame_Cont = frame_q;
  assign oBUSY       = busy_q;
  assign oROM_ADDR   = rom_addr_q;

endmodule

// File: doc/d5m_stream_gen.md
Name: d5m_stream_gen

Overview:
- Synthetic D5M sensor transmitter: drives the FVAL/LVAL/12-bit Bayer pixel stream that the capture path receives.
- It connects in place of the registered D5M_D/FVAL/LVAL inputs so the capture, RAW2RGB, SDRAM and VGA chain can be exercised without a camera.
- Pixel content is either built-in Bayer test patterns or a downscaled ROM image read through a 1-cycle-latency port.

Parameters:
- H_ACTIVE, 1280, pixels per line (LVAL-high cycles)
- V_ACTIVE, 960, active lines per frame
- H_BLANK, 160, LVAL-low cycles after each line
- FV2LV, 32, cycles with FVAL high and LVAL low before the first line
- V_BLANK, 2000, FVAL-low cycles between frames
- BAR_SHIFT, 7, colour-bar width = 2^BAR_SHIFT pixels
- ROM_SHIFT, 3, ROM downscale (ROM pixel = 2^ROM_SHIFT square of sensor pixels)
- ROM_W, 160, ROM image width in pixels
- ROM_AW, 15, ROM address width

Ports:
- iCLK  in  1  pixel clock (D5M_PIXLCLK domain)
- iRST  in  1  synchronous reset, active-high
- iSTART  in  1  pulse: begin continuous frame generation
- iSTOP  in  1  pulse: finish current frame, then idle
- iMODE  in  2  0 colour bars, 1 ramp, 2 ROM image, 3 checkerboard
- oROM_ADDR  out  ROM_AW  ROM read address
- iROM_DATA  in  12  ROM data, valid 1 cycle after address
- oDATA  out  12  pixel data
- oFVAL  out  1  frame valid
- oLVAL  out  1  line valid
- oFrame_Cont  out  32  completed-frame count
- oBUSY  out  1  high whenever not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, stop-pending cleared. Reset mid-frame forces the same on the next edge; no partial line completes.
- FSM states:
  - IDLE
  - FRONT: FV2LV cycles
  - LINE: H_ACTIVE cycles, x = 0..H_ACTIVE-1
  - HBLANK: H_BLANK cycles
  - VBLANK: V_BLANK cycles
- Transitions:
  - IDLE -> FRONT on iSTART && !iSTOP.
  - FRONT -> LINE (y = 0).
  - LINE -> HBLANK.
  - HBLANK -> LINE (y+1) if y < V_ACTIVE-1, else -> VBLANK.
  - VBLANK -> FRONT, or -> IDLE if stop pending.
- Internal (stage-0) valids:
  - fval = FRONT | LINE | HBLANK.
  - lval = LINE.
- FVAL falls on the first VBLANK cycle, so the last line's HBLANK stays inside FVAL.
- Output pipeline: one registered stage. oFVAL/oLVAL/oDATA lag stage-0 state by exactly 1 cycle; latency from iSTART to oFVAL=1 is 2 cycles.
- oDATA = 0 whenever oLVAL = 0.
- iMODE is sampled on entry to FRONT and held for the whole frame; mid-frame changes have no effect.
- iSTOP in any non-IDLE state sets stop-pending. Generation continues to the end of VBLANK, then goes to IDLE.
- iSTART while busy is ignored. Simultaneous iSTART and iSTOP in IDLE: stay IDLE.
- oFrame_Cont increments by 1 on the first VBLANK cycle and wraps 2^32-1 -> 0.
- Bayer site from (y[0], x[0]): (0,0) G1, (0,1) R, (1,0) B, (1,1) G2. The pattern selects the R/G/B value for that site.
- Colour bars: c = 7 - (x >> BAR_SHIFT)[2:0]. R = c[2] ? FFF : 000, G = c[1] ? FFF : 000, B = c[0] ? FFF : 000.
- Ramp: (x + y + frame_cnt[11:0]) mod 4096, same value at every site.
- Checkerboard: ((x>>4) ^ (y>>4))[0] ? FFF : 000.
- ROM mode:
  - oROM_ADDR = (y >> ROM_SHIFT) * ROM_W + (x >> ROM_SHIFT), truncated to ROM_AW, driven in stage 0.
  - iROM_DATA is passed to oDATA in stage 1; no Bayer selection (ROM stores raw Bayer).
  - oROM_ADDR is held at 0 outside LINE.
- Counter widths: x 12 bits, y 12 bits, blank counter 16 bits. Parameters must fit these widths; use a static assertion.

Decomposition:
- Shared package d5m_pkg holds:
  - mode encodings (MODE_BARS, MODE_RAMP, MODE_ROM, MODE_CHECK)
  - FSM state enum
  - Bayer site constants
  - counter width constants
- One sub-module, d5m_pattern_lut: combinational (mode, x, y, frame_cnt, rom_data) -> 12-bit pixel. All timing lives in the top block.

Test Plan:
All scenarios use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, FV2LV=2, V_BLANK=5, BAR_SHIFT=0.
1. Reset then one iSTART pulse:
   - oFVAL rises 2 cycles later; first oLVAL rises 2 cycles after that.
   - 4 LVAL bursts of exactly 8 cycles, separated by 3 low cycles.
   - oFVAL high for 2+4*11 = 46 cycles, then low 5 cycles.
   - oFrame_Cont 0 -> 1 when FVAL falls.
2. Colour bars, line 0: oDATA = FFF, FFF, 000, FFF, FFF, 000, 000, 000. Bayer sites G, R alternate with c = 7..0.
3. ROM mode with ROM_SHIFT=1, ROM_W=4, ROM returning data = addr:
   - Line 0 addresses 0,0,1,1,2,2,3,3; line 2 starts at address 4.
   - oDATA equals each address one cycle later.
4. iSTOP during line 2 of frame 3: frame 3 completes, oFrame_Cont = 3, oBUSY falls after VBLANK, no further FVAL.
5. iMODE changed 0 -> 3 mid-frame: current frame stays bars; next frame is checkerboard. With BAR_SHIFT irrelevant and x<16, y<16, every active pixel of that frame is 000.
6. iRST asserted mid-LINE: next cycle oFVAL = oLVAL = 0, oDATA = 0, oFrame_Cont = 0, oBUSY = 0. A later iSTART restarts cleanly at FRONT.
